// File: rtl/spi_rom_pkg.sv
// ============================================================
// spi_rom_pkg: shared constants and FSM encoding for the SPI ROM-download receiver.
// Rev 1.0
// ============================================================
`default_nettype none

package spi_rom_pkg;

  localparam logic [7:0] CMD_FILE_TX     = 8'h54;
  localparam logic [7:0] CMD_FILE_TX_DAT = 8'h53;
  localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;

  localparam logic [7:0] TX_START = 8'hFF;
  localparam logic [7:0] TX_END   = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ARG_TX  = 3'd2,
    S_ARG_IDX = 3'd3,
    S_DATA    = 3'd4,
    S_SKIP    = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_byte_deser.sv
// ============================================================
// spi_byte_deser: synchronises SPI mode-0 inputs and deserialises MSB-first bytes.
// Rev 1.0
// ============================================================
`default_nettype none

module spi_byte_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk27,
  input  logic       rst_base,
  input  logic       SPI_SCK,
  input  logic       SPI_SS2,
  input  logic       SPI_DI,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       ss_active_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] di_sync_q;
  logic                   sck_prev_q;
  logic                   armed_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;

  logic w_sck_s;
  logic w_ss_s;
  logic w_di_s;
  logic w_sck_rise;

  assign w_sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign w_ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign w_di_s     = di_sync_q[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~sck_prev_q;

  // A frame is only accepted after SS2 has been seen high once, so a reset
  // released mid-frame waits for the next genuine falling edge.
  assign ss_active_o = armed_q & ~w_ss_s;

  always_ff @(posedge clk27 or posedge rst_base) begin
    if (rst_base) begin
      sck_sync_q   <= '0;
      ss_sync_q    <= '0;
      di_sync_q    <= '0;
      sck_prev_q   <= 1'b0;
      armed_q      <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_o <= 1'b0;
      byte_o       <= 8'h00;
    end else begin
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
      ss_sync_q    <= {ss_sync_q[SYNC_STAGES-2:0], SPI_SS2};
      di_sync_q    <= {di_sync_q[SYNC_STAGES-2:0], SPI_DI};
      sck_prev_q   <= w_sck_s;
      armed_q      <= armed_q | w_ss_s;
      byte_valid_o <= 1'b0;
      if (!ss_active_o) begin
        bit_cnt_q <= 3'd0;
      end else if (w_sck_rise) begin
        shift_q   <= {shift_q[6:0], w_di_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_o <= 1'b1;
          byte_o       <= {shift_q[6:0], w_di_s};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_rom_rx.sv
// ============================================================
// spi_rom_rx: SPI file-transfer command decoder driving the ioctl_* write port.
// Rev 1.0
// ============================================================
`default_nettype none

module spi_rom_rx
  import spi_rom_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int START_ADDR  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk27,
  input  logic              rst_base,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_DI,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              ioctl_wr,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] C_START = ADDR_W'(START_ADDR);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_ss_active;

  spi_byte_deser #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deser (
    .clk27        (clk27),
    .rst_base     (rst_base),
    .SPI_SCK      (SPI_SCK),
    .SPI_SS2      (SPI_SS2),
    .SPI_DI       (SPI_DI),
    .byte_valid_o (w_byte_valid),
    .byte_o       (w_byte),
    .ss_active_o  (w_ss_active)
  );

  state_t            state_q, state_d;
  logic              download_q;
  logic [7:0]        index_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dout_q;
  logic              wr_q;
  logic              inc_q;
  logic              overflow_q;

  logic w_do_start;
  logic w_do_end;
  logic w_do_index;
  logic w_do_write;

  always_ff @(posedge clk27 or posedge rst_base) begin
    if (rst_base) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    w_do_start = 1'b0;
    w_do_end   = 1'b0;
    w_do_index = 1'b0;
    w_do_write = 1'b0;
    case (state_q)
      S_IDLE: if (w_ss_active) state_d = S_CMD;
      S_CMD: begin
        if (w_byte_valid) begin
          case (w_byte)
            CMD_FILE_TX:     state_d = S_ARG_TX;
            CMD_FILE_INDEX:  state_d = S_ARG_IDX;
            CMD_FILE_TX_DAT: state_d = S_DATA;
            default:         state_d = S_SKIP;
          endcase
        end
      end
      S_ARG_TX: begin
        if (w_byte_valid) begin
          w_do_start = (w_byte == TX_START);
          w_do_end   = (w_byte == TX_END);
          state_d    = S_SKIP;
        end
      end
      S_ARG_IDX: begin
        if (w_byte_valid) begin
          w_do_index = 1'b1;
          state_d    = S_SKIP;
        end
      end
      S_DATA:  w_do_write = w_byte_valid & download_q;
      S_SKIP:  state_d = S_SKIP;
      default: state_d = S_IDLE;
    endcase
    // A byte completing in the same cycle SS2 rises is still honoured above.
    if (!w_ss_active) state_d = S_IDLE;
  end

  always_ff @(posedge clk27 or posedge rst_base) begin
    if (rst_base) begin
      download_q <= 1'b0;
      index_q    <= 8'h00;
      addr_q     <= C_START;
      dout_q     <= 8'h00;
      wr_q       <= 1'b0;
      inc_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_q  <= w_do_write;
      inc_q <= w_do_write;
      if (w_do_write) dout_q <= w_byte;
      if (w_do_index) index_q <= w_byte;
      if (w_do_end) download_q <= 1'b0;
      // Address advances the cycle after the strobe so it is stable while wr is high.
      if (w_do_start) begin
        download_q <= 1'b1;
        addr_q     <= C_START;
        overflow_q <= 1'b0;
      end else if (inc_q) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (&addr_q) overflow_q <= 1'b1;
      end
    end
  end

  assign ioctl_download = download_q;
  assign ioctl_index    = index_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_wr       = wr_q;
  assign overflow       = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_rom_rx.sv
// ============================================================
// tb_spi_rom_rx: drives SPI frames into two spi_rom_rx instances (ADDR_W 23 and 4).
// Rev 1.0
// ============================================================
`default_nettype none

module tb_spi_rom_rx;

  logic clk27    = 1'b0;
  logic rst_base = 1'b1;
  logic SPI_SCK  = 1'b0;
  logic SPI_SS2  = 1'b1;
  logic SPI_DI   = 1'b0;

  logic        dl0, wr0, ovf0;
  logic [7:0]  idx0, dout0;
  logic [22:0] addr0;
  logic        dl1, wr1, ovf1;
  logic [7:0]  idx1, dout1;
  logic [3:0]  addr1;

  spi_rom_rx #(.ADDR_W(23), .START_ADDR(0), .SYNC_STAGES(2)) dut0 (
    .clk27(clk27), .rst_base(rst_base), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
    .ioctl_download(dl0), .ioctl_index(idx0), .ioctl_addr(addr0), .ioctl_dout(dout0),
    .ioctl_wr(wr0), .overflow(ovf0));

  spi_rom_rx #(.ADDR_W(4), .START_ADDR(0), .SYNC_STAGES(2)) dut1 (
    .clk27(clk27), .rst_base(rst_base), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
    .ioctl_download(dl1), .ioctl_index(idx1), .ioctl_addr(addr1), .ioctl_dout(dout1),
    .ioctl_wr(wr1), .overflow(ovf1));

  always #18 clk27 = ~clk27;

  int cyc = 0;
  always @(posedge clk27) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: per-instance transfer state plus expected write queues (addr<<8 | data).
  int m_dl[2], m_idx[2], m_addr[2], m_ovf[2];
  int mask[2] = '{32'h7FFFFF, 32'hF};
  int q0[$];
  int q1[$];
  int eighth_rise = 0;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_dl[k] = 0; m_idx[k] = 0; m_addr[k] = 0; m_ovf[k] = 0;
    end
    q0.delete();
    q1.delete();
  endfunction

  function automatic void model_byte(input int pos, input int cmd, input int b);
    for (int k = 0; k < 2; k++) begin
      if (pos == 1 && cmd == 8'h54) begin
        if (b == 8'hFF) begin m_dl[k] = 1; m_addr[k] = 0; m_ovf[k] = 0; end
        else if (b == 8'h00) m_dl[k] = 0;
      end else if (pos == 1 && cmd == 8'h55) begin
        m_idx[k] = b;
      end else if (pos >= 1 && cmd == 8'h53 && m_dl[k] == 1) begin
        if (k == 0) q0.push_back((m_addr[k] << 8) | b);
        else        q1.push_back((m_addr[k] << 8) | b);
        m_addr[k] = (m_addr[k] + 1) & mask[k];
        if (m_addr[k] == 0) m_ovf[k] = 1;
      end
    end
  endfunction

  // Compare process: every write strobe is checked against the model queue.
  logic pwr0 = 1'b0, pwr1 = 1'b0;
  int   e0, e1;
  always @(negedge clk27) begin
    if (!rst_base) begin
      if (wr0) begin
        chk("wr0_width", pwr0, 0);
        if (q0.size() == 0) chk("wr0_unexpected", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("wr0_addr", addr0, e0 >> 8);
          chk("wr0_data", dout0, e0 & 255);
          chk("wr0_latency", cyc - eighth_rise, 4);
        end
      end
      if (wr1) begin
        chk("wr1_width", pwr1, 0);
        if (q1.size() == 0) chk("wr1_unexpected", 1, 0);
        else begin
          e1 = q1.pop_front();
          chk("wr1_addr", addr1, e1 >> 8);
          chk("wr1_data", dout1, e1 & 255);
        end
      end
    end
    pwr0 = wr0;
    pwr1 = wr1;
  end

  int fr[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk27);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dl"}, dl0, 0);
    chk({tag, "_idx"}, idx0, 0);
    chk({tag, "_addr0"}, addr0, 0);
    chk({tag, "_addr1"}, addr1, 0);
    chk({tag, "_dout"}, dout0, 0);
    chk({tag, "_wr"}, wr0, 0);
    chk({tag, "_ovf"}, ovf0, 0);
  endtask

  task automatic send_frame(input int nbits, input int h, input int rst_bit);
    int dead;
    dead = 0;
    SPI_SS2 = 1'b0;
    tick(h + 2);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst_base = 1'b1;
        tick(2);
        model_reset();
        dead = 1;
        chk_reset_vals("midreset");
        rst_base = 1'b0;
      end
      SPI_DI = 1'((fr[i/8] >> (7 - (i % 8))) & 1);
      tick(h);
      SPI_SCK = 1'b1;
      if ((i % 8) == 7 && dead == 0) begin
        eighth_rise = cyc;
        model_byte(i / 8, fr[0], fr[i/8]);
      end
      tick(h);
      SPI_SCK = 1'b0;
    end
    tick(h + 1);
    SPI_SS2 = 1'b1;
    tick(8);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_dl0"}, dl0, m_dl[0]);
    chk({tag, "_idx0"}, idx0, m_idx[0]);
    chk({tag, "_addr0"}, addr0, m_addr[0]);
    chk({tag, "_ovf0"}, ovf0, m_ovf[0]);
    chk({tag, "_dl1"}, dl1, m_dl[1]);
    chk({tag, "_addr1"}, addr1, m_addr[1]);
    chk({tag, "_ovf1"}, ovf1, m_ovf[1]);
  endtask

  task automatic frame2(input int a, input int b);
    fr.delete(); fr.push_back(a); fr.push_back(b);
    send_frame(16, 2, -1);
  endtask

  initial begin
    #(36 * 2 * 80000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int len, kind, nb, h;
    model_reset();
    tick(3);
    chk_reset_vals("reset");
    rst_base = 1'b0;
    tick(6);

    frame2(8'h55, 8'h03);
    frame2(8'h54, 8'hFF);
    chk("t1_index", idx0, 8'h03);
    chk("t1_download", dl0, 1);
    chk("t1_addr", addr0, 0);
    check_state("t1");

    fr.delete(); fr.push_back(8'h53); fr.push_back(8'hA5); fr.push_back(8'h5A); fr.push_back(8'h01);
    send_frame(32, 3, -1);
    chk("t2_addr", addr0, 3);
    chk("t2_dout", dout0, 8'h01);
    check_state("t2");

    frame2(8'h54, 8'h00);
    frame2(8'h53, 8'h77);
    chk("t3_download", dl0, 0);
    chk("t3_addr", addr0, 3);
    check_state("t3");

    frame2(8'h54, 8'hFF);
    fr.delete(); fr.push_back(8'h53); fr.push_back(8'hC3);
    send_frame(13, 2, -1);
    chk("t4_partial_addr", addr0, 0);
    frame2(8'h53, 8'h10);
    chk("t4_addr", addr0, 1);
    chk("t4_dout", dout0, 8'h10);
    check_state("t4");

    frame2(8'h54, 8'hFF);
    fr.delete(); fr.push_back(8'h53);
    for (int i = 0; i < 17; i++) fr.push_back(8'h20 + i);
    send_frame(8 * 18, 2, -1);
    chk("t5_addr1", addr1, 1);
    chk("t5_ovf1", ovf1, 1);
    chk("t5_dout1", dout1, 8'h30);
    chk("t5_ovf0", ovf0, 0);
    check_state("t5");
    frame2(8'h54, 8'hFF);
    chk("t5_ovf_clear", ovf1, 0);

    fr.delete(); fr.push_back(8'h53); fr.push_back(8'h11); fr.push_back(8'h22); fr.push_back(8'h33);
    send_frame(32, 2, 19);
    chk_reset_vals("postreset");
    frame2(8'h54, 8'hFF);
    frame2(8'h53, 8'h99);
    chk("t6_addr", addr0, 1);
    chk("t6_dout", dout0, 8'h99);
    check_state("t6");

    for (int n = 0; n < 30; n++) begin
      fr.delete();
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 6);
      fr.push_back(kind == 0 ? 8'h53 : kind == 1 ? 8'h54 : kind == 2 ? 8'h55 : $urandom_range(0, 255));
      for (int p = 1; p < len; p++) begin
        if (p == 1 && fr[0] == 8'h54) begin
          case ($urandom_range(0, 2))
            0:       fr.push_back(8'hFF);
            1:       fr.push_back(8'h00);
            default: fr.push_back($urandom_range(0, 255));
          endcase
        end else fr.push_back($urandom_range(0, 255));
      end
      nb = 8 * len;
      if ($urandom_range(0, 4) == 0) nb -= $urandom_range(1, 7);
      h = $urandom_range(2, 4);
      send_frame(nb, h, -1);
      check_state("rand");
    end

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
